// File: rtl/mem_io_responder.sv
// Byte-wide bus responder: RAM, I/O window (UART rx/tx, cycle counter,
// program stop) and the CPU ready/stall handshake.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 16,
  parameter     INIT_FILE  = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FullCnt = (PW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {
    IDLE, WAIT_RX, WAIT_TX, STOP
  } state_e;

  state_e          state_q;
  logic [7:0]      ram_q [2**ADDR_WIDTH];
  logic [7:0]      fifo_q [TX_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW:0]     count_q;
  logic [7:0]      hold_q, cpu_din_q;
  logic            rdy_q, stop_q;
  logic [31:0]     cnt_q;

  logic idle, is_ram, is_hole, is_io;
  logic io_rx_rd, io_tx_wr;
  logic full, push, pop;
  logic [7:0] push_d;
  logic unused_a;

  assign unused_a = ^cpu_a[31:18];

  assign idle     = (state_q == IDLE);
  assign is_ram   = !cpu_a[17];
  assign is_hole  = (cpu_a[17:16] == 2'b10);
  assign is_io    = (cpu_a[17:16] == 2'b11);
  assign io_rx_rd = is_io && cpu_a[2:0] == 3'd0
                    && !cpu_wr;
  assign io_tx_wr = is_io && cpu_a[2:0] == 3'd0
                    && cpu_wr && cpu_dout != 8'h00;

  assign rx_ready = !rst_in &&
                    ((idle && io_rx_rd) ||
                     state_q == WAIT_RX);

  // Full is taken before the same-cycle pop.
  assign full     = (count_q == FullCnt);
  assign tx_valid = (count_q != '0);
  assign tx_data  = tx_valid ? fifo_q[rd_ptr_q]
                             : 8'h00;
  assign pop      = tx_valid && tx_ready;

  always_comb begin
    push   = 1'b0;
    push_d = cpu_dout;
    if (!full) begin
      if (idle && io_tx_wr) begin
        push = 1'b1;
      end else if (state_q == WAIT_TX) begin
        push   = 1'b1;
        push_d = hold_q;
      end
    end
  end

  assign cpu_din   = cpu_din_q;
  assign rdy_out   = rdy_q;
  assign prog_stop = stop_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in && idle && is_ram && cpu_wr)
      ram_q[cpu_a[ADDR_WIDTH-1:0]] <= cpu_dout;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push)
      fifo_q[wr_ptr_q] <= push_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cpu_din_q <= 8'h00;
      rdy_q     <= 1'b1;
      stop_q    <= 1'b0;
      hold_q    <= 8'h00;
      cnt_q     <= 32'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: ;
      endcase

      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_ram: begin
              if (!cpu_wr)
                cpu_din_q <=
                  ram_q[cpu_a[ADDR_WIDTH-1:0]];
            end
            is_hole: begin
              if (!cpu_wr) cpu_din_q <= 8'h00;
            end
            is_io: begin
              if (!cpu_wr) begin
                if (cpu_a[2]) begin
                  cpu_din_q <=
                    cnt_q[{cpu_a[1:0], 3'b000} +: 8];
                end else if (io_rx_rd) begin
                  if (rx_valid) begin
                    cpu_din_q <= rx_data;
                  end else begin
                    state_q <= WAIT_RX;
                    rdy_q   <= 1'b0;
                  end
                end else begin
                  cpu_din_q <= 8'h00;
                end
              end else if (cpu_a[2:0] == 3'd4) begin
                stop_q  <= 1'b1;
                state_q <= STOP;
                rdy_q   <= 1'b0;
              end else if (io_tx_wr && full) begin
                hold_q  <= cpu_dout;
                state_q <= WAIT_TX;
                rdy_q   <= 1'b0;
              end
            end
          endcase
        end
        WAIT_RX: begin
          if (rx_valid) begin
            cpu_din_q <= rx_data;
            state_q   <= IDLE;
            rdy_q     <= 1'b1;
          end
        end
        WAIT_TX: begin
          if (!full) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        STOP: ;
      endcase
    end
  end

endmodule
